// File: rtl/alu_pkg.sv
// Shared definitions for the alu controller: alu opcodes, instruction field
// layout and the controller FSM encoding.
package alu_pkg;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_XOR   = 4'd4;
    localparam logic [3:0] ALU_SHL   = 4'd5;
    localparam logic [3:0] ALU_SHR   = 4'd6;
    localparam logic [3:0] ALU_NOT   = 4'd7;
    localparam logic [3:0] ALU_INC   = 4'd8;
    localparam logic [3:0] ALU_MAXOP = 4'd8;

    // instr = {code[9:6], rd[5:4], ra[3:2], rb[1:0]}
    localparam int INSTR_W  = 10;
    localparam int CODE_LSB = 6;
    localparam int CODE_W   = 4;
    localparam int RD_LSB   = 4;
    localparam int RA_LSB   = 2;
    localparam int RB_LSB   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_EXEC = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    function automatic logic code_legal(input logic [CODE_W-1:0] code);
        return code <= ALU_MAXOP;
    endfunction

endpackage

// File: rtl/alu_ctrl_if.sv
// Instruction, preload and alu-side signals of the alu controller.
// Handshakes: a transfer happens on a rising edge where valid && ready are both high.
interface alu_ctrl_if #(
    parameter int LEN = 8,
    parameter int AW  = 2
) ();
    import alu_pkg::*;

    logic                instr_valid;
    logic                instr_ready;
    logic [INSTR_W-1:0]  instr;
    logic                ld_valid;
    logic                ld_ready;
    logic [AW-1:0]       ld_addr;
    logic [LEN-1:0]      ld_data;
    logic [LEN-1:0]      alu_a;
    logic [LEN-1:0]      alu_b;
    logic [CODE_W-1:0]   alu_code;
    logic [LEN-1:0]      alu_out;
    logic                done;
    logic [LEN-1:0]      result;
    logic                err;
    state_t              fsm_state;

    modport slave (
        input  instr_valid, instr, ld_valid, ld_addr, ld_data, alu_out,
        output instr_ready, ld_ready, alu_a, alu_b, alu_code, done, result, err,
               fsm_state
    );

    modport master (
        output instr_valid, instr, ld_valid, ld_addr, ld_data, alu_out,
        input  instr_ready, ld_ready, alu_a, alu_b, alu_code, done, result, err,
               fsm_state
    );

endinterface

// File: rtl/alu_ctrl_rf.sv
// NREG x LEN register file: two async read ports, one sync write, sync clear.
// With ALU_CTRL_DBG_EN defined a third async read port is added for debug.
module alu_ctrl_rf #(
    parameter int LEN  = 8,
    parameter int NREG = 4,
    parameter int AW   = $clog2(NREG)
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           we,
    input  logic [AW-1:0]  waddr,
    input  logic [LEN-1:0] wdata,
    input  logic [AW-1:0]  raddr_a,
    output logic [LEN-1:0] rdata_a,
    input  logic [AW-1:0]  raddr_b,
    output logic [LEN-1:0] rdata_b
`ifdef ALU_CTRL_DBG_EN
    ,
    input  logic [AW-1:0]  dbg_addr,
    output logic [LEN-1:0] dbg_data
`endif
);

    logic [LEN-1:0] mem [NREG];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata_a = mem[raddr_a];
    assign rdata_b = mem[raddr_b];

`ifdef ALU_CTRL_DBG_EN
    assign dbg_data = mem[dbg_addr];
`endif

endmodule

// File: rtl/alu_ctrl.sv
// Multi-cycle controller for the combinational alu: IDLE -> READ -> EXEC -> WB.
// Optional debug read port of the register file enabled by ALU_CTRL_DBG_EN.
module alu_ctrl
    import alu_pkg::*;
#(
    parameter int LEN  = 8,
    parameter int NREG = 4
) (
    input  logic clk,
    input  logic rst,
    alu_ctrl_if.slave bus
`ifdef ALU_CTRL_DBG_EN
    ,
    input  logic [$clog2(NREG)-1:0] dbg_addr,
    output logic [LEN-1:0]          dbg_data
`endif
);

    localparam int AW = $clog2(NREG);

    state_t             state;
    logic [INSTR_W-1:0] instr_q;
    logic [LEN-1:0]     result_q;
    logic               illegal_q;

    logic [CODE_W-1:0]  code;
    logic [AW-1:0]      rd;
    logic [AW-1:0]      ra;
    logic [AW-1:0]      rb;
    logic [LEN-1:0]     rdata_a;
    logic [LEN-1:0]     rdata_b;
    logic               ld_fire;
    logic               wb_fire;
    logic               rf_we;
    logic [AW-1:0]      rf_waddr;
    logic [LEN-1:0]     rf_wdata;

    assign code = instr_q[CODE_LSB +: CODE_W];
    assign rd   = instr_q[RD_LSB +: AW];
    assign ra   = instr_q[RA_LSB +: AW];
    assign rb   = instr_q[RB_LSB +: AW];

    assign bus.instr_ready = (state == ST_IDLE);
    // A pending instruction always takes priority over a preload.
    assign bus.ld_ready    = (state == ST_IDLE) && !bus.instr_valid;
    assign bus.fsm_state   = state;

    assign ld_fire = bus.ld_valid && bus.ld_ready;
    assign wb_fire = (state == ST_WB) && !illegal_q;

    // Preloads only happen in IDLE and writeback only in WB, so they never collide.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = bus.ld_addr;
        rf_wdata = bus.ld_data;
        if (wb_fire) begin
            rf_we    = 1'b1;
            rf_waddr = rd;
            rf_wdata = result_q;
        end else if (ld_fire) begin
            rf_we    = 1'b1;
        end
    end

    alu_ctrl_rf #(
        .LEN  (LEN),
        .NREG (NREG),
        .AW   (AW)
    ) u_rf (
        .clk     (clk),
        .rst     (rst),
        .we      (rf_we),
        .waddr   (rf_waddr),
        .wdata   (rf_wdata),
        .raddr_a (ra),
        .rdata_a (rdata_a),
        .raddr_b (rb),
        .rdata_b (rdata_b)
`ifdef ALU_CTRL_DBG_EN
        ,
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
`endif
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_IDLE;
            instr_q      <= '0;
            result_q     <= '0;
            illegal_q    <= 1'b0;
            bus.alu_a    <= '0;
            bus.alu_b    <= '0;
            bus.alu_code <= '0;
            bus.result   <= '0;
            bus.done     <= 1'b0;
            bus.err      <= 1'b0;
        end else begin
            bus.done <= 1'b0;
            bus.err  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.instr_valid) begin
                        instr_q <= bus.instr;
                        state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    bus.alu_a <= rdata_a;
                    bus.alu_b <= rdata_b;
                    if (code_legal(code)) begin
                        bus.alu_code <= code;
                        illegal_q    <= 1'b0;
                    end else begin
                        bus.alu_code <= '0;
                        illegal_q    <= 1'b1;
                    end
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Operands were registered last edge, so alu_out has had a full cycle.
                    result_q <= bus.alu_out;
                    state    <= ST_WB;
                end
                ST_WB: begin
                    bus.done   <= 1'b1;
                    bus.err    <= illegal_q;
                    bus.result <= illegal_q ? '0 : result_q;
                    state      <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed + light random bench for alu_ctrl with a behavioural alu beside it.
// Expected results go into a queue at issue time and are checked at done.
module tb_alu_ctrl;
    import alu_pkg::*;

    logic clk;
    logic rst;

    alu_ctrl_if #(.LEN(8), .AW(2)) bus ();

`ifdef ALU_CTRL_DBG_EN
    logic [1:0] dbg_addr;
    logic [7:0] dbg_data;
    assign dbg_addr = 2'd0;
`endif

    alu_ctrl #(.LEN(8), .NREG(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef ALU_CTRL_DBG_EN
        ,
        .dbg_addr(dbg_addr),
        .dbg_data(dbg_data)
`endif
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- alu model ----------------
    function automatic logic [7:0] alu_ref(input logic [3:0] c, input logic [7:0] a,
                                           input logic [7:0] b);
        case (c)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << 1;
            4'd6: return a >> 1;
            4'd7: return ~a;
            4'd8: return a + 8'd1;
            default: return 8'h00;
        endcase
    endfunction

    always_comb bus.alu_out = alu_ref(bus.alu_code, bus.alu_a, bus.alu_b);

    // ---------------- scoreboard ----------------
    logic [7:0] exp_q[$];
    logic       err_q[$];
    logic [7:0] shadow [4];
    bit         pend_wr;
    logic [1:0] pend_rd;
    logic [7:0] pend_val;
    int         n_checks = 0;
    int         n_fails  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [1:0] addr, input logic [7:0] data);
        int w;
        bus.ld_addr  = addr;
        bus.ld_data  = data;
        bus.ld_valid = 1'b1;
        w = 0;
        while (!bus.ld_ready && w < 20) begin
            tick();
            w++;
        end
        tick();
        bus.ld_valid = 1'b0;
        shadow[addr] = data;
    endtask

    task automatic issue(input logic [3:0] c, input logic [1:0] rd, input logic [1:0] ra,
                         input logic [1:0] rb);
        int w;
        logic [7:0] e;
        bus.instr       = {c, rd, ra, rb};
        bus.instr_valid = 1'b1;
        w = 0;
        while (!bus.instr_ready && w < 20) begin
            tick();
            w++;
        end
        check("instr_ready_at_issue", bus.instr_ready, 1);
        if (c <= 4'd8) begin
            e = alu_ref(c, shadow[ra], shadow[rb]);
            exp_q.push_back(e);
            err_q.push_back(1'b0);
            pend_wr  = 1'b1;
            pend_rd  = rd;
            pend_val = e;
        end else begin
            exp_q.push_back(8'h00);
            err_q.push_back(1'b1);
            pend_wr = 1'b0;
        end
        tick();
        bus.instr_valid = 1'b0;
    endtask

    // Called right after the accepting edge; done must appear exactly 3 edges later.
    task automatic wait_done(input bit check_ld);
        int lat;
        logic [7:0] e;
        logic       ee;
        lat = 0;
        while (lat < 12) begin
            if (check_ld) check("ld_ready_busy", bus.ld_ready, 0);
            tick();
            lat++;
            if (bus.done) break;
        end
        check("done_latency", lat, 3);
        if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            ee = err_q.pop_front();
            check("result", bus.result, e);
            check("err", bus.err, ee);
            if (pend_wr) shadow[pend_rd] = pend_val;
        end
    endtask

    task automatic read_reg(input logic [1:0] r);
        issue(ALU_OR, r, r, r);
        wait_done(1'b0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        bus.instr_valid = 1'b0;
        bus.instr       = '0;
        bus.ld_valid    = 1'b0;
        bus.ld_addr     = '0;
        bus.ld_data     = '0;
        for (int i = 0; i < 4; i++) shadow[i] = 8'h00;
        pend_wr = 1'b0;
        pend_rd = '0;
        pend_val = '0;

        // 1: reset state
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        check("rst_instr_ready", bus.instr_ready, 1);
        check("rst_done", bus.done, 0);
        check("rst_err", bus.err, 0);
        check("rst_result", bus.result, 0);
        check("rst_alu_a", bus.alu_a, 0);
        check("rst_alu_b", bus.alu_b, 0);
        check("rst_alu_code", bus.alu_code, 0);
        check("rst_state", bus.fsm_state, ST_IDLE);
        for (int r = 0; r < 4; r++) read_reg(2'(r));

        // 2: ADD then SUB
        preload(2'd0, 8'd4);
        preload(2'd1, 8'd1);
        issue(ALU_ADD, 2'd2, 2'd0, 2'd1);
        wait_done(1'b0);
        tick();
        check("done_pulse_width", bus.done, 0);
        read_reg(2'd2);
        issue(ALU_SUB, 2'd3, 2'd0, 2'd1);
        wait_done(1'b0);

        // 3: opcode sweep plus illegal codes
        for (int c = 0; c <= 8; c++) begin
            issue(4'(c), 2'd2, 2'd0, 2'd1);
            wait_done(1'b0);
        end
        issue(4'd9, 2'd2, 2'd0, 2'd1);
        wait_done(1'b0);
        read_reg(2'd2);
        issue(4'd15, 2'd3, 2'd0, 2'd1);
        wait_done(1'b0);
        read_reg(2'd3);

        // 4: instruction and preload offered together
        bus.ld_addr  = 2'd3;
        bus.ld_data  = 8'h77;
        bus.ld_valid = 1'b1;
        bus.instr    = {ALU_ADD, 2'd2, 2'd0, 2'd1};
        bus.instr_valid = 1'b1;
        #1;
        check("ld_yields_to_instr", bus.ld_ready, 0);
        issue(ALU_ADD, 2'd2, 2'd0, 2'd1);
        wait_done(1'b1);
        check("ld_ready_back_idle", bus.ld_ready, 1);
        tick();
        bus.ld_valid = 1'b0;
        shadow[3] = 8'h77;
        read_reg(2'd3);

        // 5: rd==ra with wrap-around, then consumer of the new value
        preload(2'd0, 8'hFF);
        preload(2'd1, 8'h01);
        issue(ALU_ADD, 2'd0, 2'd0, 2'd1);
        wait_done(1'b0);
        issue(ALU_ADD, 2'd3, 2'd0, 2'd1);
        wait_done(1'b0);

        // 6: reset while in EXEC aborts the instruction
        preload(2'd0, 8'd4);
        preload(2'd1, 8'd1);
        preload(2'd2, 8'h33);
        issue(ALU_ADD, 2'd2, 2'd0, 2'd1);
        tick();
        check("in_exec_before_rst", bus.fsm_state, ST_EXEC);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_state_idle", bus.fsm_state, ST_IDLE);
        check("abort_result", bus.result, 0);
        for (int k = 0; k < 4; k++) begin
            check("abort_no_done", bus.done, 0);
            tick();
        end
        void'(exp_q.pop_back());
        void'(err_q.pop_back());
        pend_wr = 1'b0;
        for (int i = 0; i < 4; i++) shadow[i] = 8'h00;
        read_reg(2'd2);
        read_reg(2'd0);

        // random mix of preloads and instructions, some illegal
        for (int n = 0; n < 8; n++) begin
            preload(2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)));
            issue(4'($urandom_range(0, 10)), 2'($urandom_range(0, 3)),
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
            wait_done(1'b0);
        end
        for (int r = 0; r < 4; r++) read_reg(2'(r));

        check("scoreboard_empty", exp_q.size(), 0);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
